// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus sequencer.
//   state_e     : sequencer FSM states
//   DefPat0..3  : power-on contents of pattern-table entries 0..3
//   def_word()  : reset value of any table entry (entries above 3 are zero)
package stim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitTick,
    StSend,
    StDone
  } state_e;

  localparam logic [3:0] DefPat0 = 4'b0000;
  localparam logic [3:0] DefPat1 = 4'b0011;
  localparam logic [3:0] DefPat2 = 4'b1100;
  localparam logic [3:0] DefPat3 = 4'b1111;

  function automatic logic [3:0] def_word(input int unsigned i);
    case (i)
      0:       def_word = DefPat0;
      1:       def_word = DefPat1;
      2:       def_word = DefPat2;
      3:       def_word = DefPat3;
      default: def_word = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/rst_sync_n.sv
// Active-low reset synchronizer: asserts asynchronously, releases after two
// rising clock edges.
//   i_clk   : clock
//   i_rst_n : raw asynchronous active-low reset
//   o_rst_n : synchronized active-low reset
module rst_sync_n (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic r_ff1;
  logic r_ff2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
    end else begin
      r_ff1 <= 1'b1;
      r_ff2 <= r_ff1;
    end
  end

  assign o_rst_n = r_ff2;

endmodule

// File: rtl/stim_sequencer.sv
// Pattern-table stimulus sequencer. On start it walks the table, presenting
// one word per tick2-paced valid/ready handshake, and ends the run after the
// last word or after TIMEOUT cycles, whichever comes first.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_start                   : run request (IDLE only)
//   i_load_en/addr/data       : pattern-table write port (IDLE only)
//   o_out_valid/data, i_out_ready : output word handshake
//   o_tick2, o_tick4          : clk/2 and clk/4 single-cycle enables
//   o_busy, o_done, o_timeout : run in progress, run-end pulse, timeout flag
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_load_en,
  input  logic [$clog2(DEPTH)-1:0] i_load_addr,
  input  logic [DATA_W-1:0]        i_load_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DATA_W-1:0]        o_out_data,
  output logic                     o_tick2,
  output logic                     o_tick4,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic              w_rst_n;
  logic [1:0]        r_cnt;
  state_e            r_state, w_state_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [CW-1:0]     r_cyc, w_cyc_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [DATA_W-1:0] r_table [DEPTH];
  logic              w_load_we;
  logic              w_hs;
  logic              w_last;
  logic              w_expire;

  rst_sync_n u_rst_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_rst_n (w_rst_n)
  );

  // Free-running tick counter.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt <= 2'd0;
    end else begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_tick2 = r_cnt[0];
  assign o_tick4 = (r_cnt == 2'd3);

  assign o_out_valid = (r_state == StSend);
  assign o_out_data  = o_out_valid ? r_table[r_idx] : '0;
  assign o_busy      = (r_state == StWaitTick) || (r_state == StSend);
  assign o_done      = (r_state == StDone);
  assign o_timeout   = r_timeout;

  assign w_hs     = o_out_valid && i_out_ready;
  assign w_last   = (r_idx == AW'(DEPTH - 1));
  assign w_expire = (r_cyc == CW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cyc_nxt     = r_cyc;
    w_timeout_nxt = r_timeout;
    w_load_we     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_load_we = i_load_en;
        if (i_start) begin
          w_state_nxt   = StWaitTick;
          w_idx_nxt     = '0;
          w_cyc_nxt     = '0;
          w_timeout_nxt = 1'b0;
        end
      end
      StWaitTick: begin
        w_cyc_nxt = r_cyc + CW'(1);
        if (w_expire) begin
          w_state_nxt   = StDone;
          w_timeout_nxt = 1'b1;
        end else if (o_tick2) begin
          w_state_nxt = StSend;
        end
      end
      StSend: begin
        w_cyc_nxt = r_cyc + CW'(1);
        // A handshake in the expiry cycle still counts; the run only counts
        // as timed out if words remain after it.
        if (w_hs && w_last) begin
          w_state_nxt = StDone;
        end else if (w_expire) begin
          w_state_nxt   = StDone;
          w_timeout_nxt = 1'b1;
          if (w_hs) begin
            w_idx_nxt = r_idx + AW'(1);
          end
        end else if (w_hs) begin
          w_idx_nxt   = r_idx + AW'(1);
          w_state_nxt = StWaitTick;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_cyc     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cyc     <= w_cyc_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Pattern table; reset restores the default patterns.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_table[i] <= DATA_W'(def_word(unsigned'(i)));
      end
    end else if (w_load_we) begin
      r_table[i_load_addr] <= i_load_data;
    end
  end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, the pattern word width.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of pattern entries (power of 2, at least 2).
REQ-003 The block SHALL have parameter TIMEOUT, default 20, the maximum clk cycles per run, counted from start acceptance.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-007 The block SHALL have port load_en, input, 1 bit: pattern-table write strobe, honoured in IDLE only.
REQ-008 The block SHALL have port load_addr, input, $clog2(DEPTH) bits: pattern-table write index.
REQ-009 The block SHALL have port load_data, input, DATA_W bits: pattern-table write data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-012 The block SHALL have port out_data, output, DATA_W bits: the current pattern word.
REQ-013 The block SHALL have ports tick2 and tick4, output, 1 bit each: single-cycle enables at clk/2 and clk/4.
REQ-014 The block SHALL have ports busy, done and timeout, output, 1 bit each: run in progress, run-end pulse, and run-ended-by-timeout flag.

Function
REQ-015 A 2-bit free-running counter cnt SHALL increment every cycle after reset release.
- tick2 = cnt[0].
- tick4 = (cnt == 3).
REQ-016 The FSM SHALL have states IDLE, WAIT_TICK, SEND and DONE.
REQ-017 IDLE with start=1 SHALL go to WAIT_TICK, clear idx and the cycle counter, and set busy=1 from the next cycle.
REQ-018 In IDLE, load_en=1 SHALL write load_data to table[load_addr] that cycle; load_en in any other state SHALL be ignored.
REQ-019 If load_en and start are both high in IDLE, the write SHALL complete and the run SHALL start; the run uses the written value.
REQ-020 WAIT_TICK with tick2=1 SHALL go to SEND.
REQ-021 SEND SHALL drive out_valid=1 and out_data=table[idx].
- out_data stays stable until the handshake.
REQ-022 A handshake SHALL occur when out_valid and out_ready are both 1 in a cycle.
- idx != DEPTH-1: idx increments and the FSM goes to WAIT_TICK.
- idx == DEPTH-1: the FSM goes to DONE; idx does not wrap.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 The cycle counter SHALL increment every cycle in WAIT_TICK or SEND.
REQ-025 When the cycle counter reaches TIMEOUT-1, the FSM SHALL go to DONE and set timeout=1; out_valid drops in that transition even if unacknowledged.
REQ-026 If a handshake and the timeout fall in the same cycle, the handshake SHALL count; timeout SHALL be set only if words remain unsent.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, clear busy, then return to IDLE.
REQ-028 The timeout flag SHALL hold until the next start acceptance.
REQ-029 start asserted outside IDLE SHALL be ignored; no queuing.

Reset
REQ-030 rst=0 SHALL asynchronously force the outputs as follows:
- FSM=IDLE; cnt=0; idx=0.
- out_valid=0; out_data=0; tick2=0; tick4=0.
- busy=0; done=0; timeout=0.
- table = {0000, 0011, 1100, 1111} (entries 0..3; entries beyond 3 cleared).
REQ-031 Reset release SHALL pass through a 2-flop synchronizer; internal state leaves reset on the second rising clk edge after rst rises.
REQ-032 Reset asserted mid-run SHALL abort the run immediately, with no done pulse.

Structure
REQ-033 The shared package stim_pkg SHALL hold the FSM state enum and the default pattern constants.
REQ-034 The reset synchronizer SHALL be a separate sub-module rst_sync_n (2 flops, async assert, sync deassert).
REQ-035 The top SHALL contain the tick counter, FSM, pattern table and timeout counter; 120-400 lines total.

Verification
REQ-036 Basic run: release rst, pulse start, hold out_ready=1 -> out_data 0000, 0011, 1100, 1111 on successive tick2-paced handshakes, then done for 1 cycle, timeout=0.
REQ-037 Tick check: run 16 free cycles after reset release -> tick2 high 8 cycles, tick4 high 4 cycles, tick4 always coincident with tick2.
REQ-038 Backpressure: out_ready=0 for 5 cycles on word 1 -> out_valid held, out_data stays 0011, no idx change.
REQ-039 Timeout: out_ready=0 permanently, TIMEOUT=20 -> done and timeout asserted together, 20 cycles after start acceptance, out_valid=0 afterwards.
REQ-040 Load: in IDLE write table[2]=1010, then start -> third word 1010; a load_en during the run leaves the table unchanged.
REQ-041 Reset mid-run: drop rst during SEND -> all outputs 0 in the same cycle, table back to defaults, no done; operation resumes 2 edges after rst rises.
